// File: rtl/coz_yurut_asamasi_pkg.sv
// coz_yurut_paket: opcodes, FSM states, ALU op codes and the default PC shared by the decode/execute stage
package coz_yurut_paket;
    localparam logic [6:0] OP     = 7'h33;
    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] LUI    = 7'h37;
    localparam logic [6:0] AUIPC  = 7'h17;
    localparam logic [6:0] JAL    = 7'h6F;
    localparam logic [6:0] JALR   = 7'h67;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [31:0] VARSAYILAN_PS = 32'h8000_0000;
    typedef enum logic [1:0] {BOSTA, COZ, YURUT, GERIYAZ} durum_t;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;
endpackage

// File: rtl/coz_yurut_asamasi_if.sv
// coz_yurut_asamasi_if: fetch <-> decode/execute handshake and next-PC return path
interface coz_yurut_asamasi_if #(parameter int VERI_BIT = 32, parameter int ADRES_BIT = 32);
    logic                 buyruk_gecerli;
    logic [VERI_BIT-1:0]  buyruk;
    logic [ADRES_BIT-1:0] buyruk_ps;
    logic                 buyruk_hazir;
    logic [ADRES_BIT-1:0] sonraki_ps;
    logic                 sonraki_ps_gecerli;
    logic                 gecersiz_buyruk;
    modport master (output buyruk_gecerli, buyruk, buyruk_ps,
                    input  buyruk_hazir, sonraki_ps, sonraki_ps_gecerli, gecersiz_buyruk);
    modport slave  (input  buyruk_gecerli, buyruk, buyruk_ps,
                    output buyruk_hazir, sonraki_ps, sonraki_ps_gecerli, gecersiz_buyruk);
endinterface

// File: rtl/coz_yurut_asamasi_alu.sv
// aritmetik_mantik_birimi: combinational RV32I ALU with equal / signed-less / unsigned-less comparator
module aritmetik_mantik_birimi
    import coz_yurut_paket::*;
#(
    parameter int VERI_BIT = 32
) (
    input  alu_op_t             op,
    input  logic [VERI_BIT-1:0] a,
    input  logic [VERI_BIT-1:0] b,
    output logic [VERI_BIT-1:0] sonuc,
    output logic                esit,
    output logic                kucuk,
    output logic                kucuk_isaretsiz
);
    logic [4:0] kaydir;
    assign kaydir          = b[4:0];
    assign esit            = a == b;
    assign kucuk           = $signed(a) < $signed(b);
    assign kucuk_isaretsiz = a < b;
    always_comb begin
        sonuc = a + b;
        case (op)
            ALU_SUB:  sonuc = a - b;
            ALU_SLL:  sonuc = a << kaydir;
            ALU_SLT:  sonuc = {{(VERI_BIT-1){1'b0}}, kucuk};
            ALU_SLTU: sonuc = {{(VERI_BIT-1){1'b0}}, kucuk_isaretsiz};
            ALU_XOR:  sonuc = a ^ b;
            ALU_SRL:  sonuc = a >> kaydir;
            ALU_SRA:  sonuc = $signed(a) >>> kaydir;
            ALU_OR:   sonuc = a | b;
            ALU_AND:  sonuc = a & b;
            default:  ;
        endcase
    end
endmodule

// File: rtl/coz_yurut_asamasi.sv
// coz_yurut_asamasi: multicycle RV32I decode / register-read / execute / write-back stage with register file
module coz_yurut_asamasi
    import coz_yurut_paket::*;
#(
    parameter int VERI_BIT      = 32,
    parameter int ADRES_BIT     = 32,
    parameter int YAZMAC_SAYISI = 32
) (
    input  logic                clk,
    input  logic                rst,
    coz_yurut_asamasi_if.slave  bus,
    input  logic [4:0]          hata_ayikla_adres,
    output logic [VERI_BIT-1:0] hata_ayikla_veri
);
    durum_t durum, sonraki_durum;
    logic [31:0] buyruk_r;
    logic [ADRES_BIT-1:0] ps_r, hedef_ham, hedef, sonraki;
    logic [VERI_BIT-1:0] yazmac [YAZMAC_SAYISI];
    logic [VERI_BIT-1:0] rs1_v, rs2_v, imm, a, b, a_r, b_r, rs1_r, imm_r, sonuc, sonuc_r;
    alu_op_t alu_op, op_r;
    logic yasal, esit, kucuk, kucuk_i, kosul, atla, gecersiz, yaz, yaz_r, gecersiz_r;
    logic [6:0] opk, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    assign opk = buyruk_r[6:0];
    assign rd  = buyruk_r[11:7];
    assign f3  = buyruk_r[14:12];
    assign rs1 = buyruk_r[19:15];
    assign rs2 = buyruk_r[24:20];
    assign f7  = buyruk_r[31:25];
    assign hata_ayikla_veri = hata_ayikla_adres == 5'd0 ? '0 : yazmac[hata_ayikla_adres];
    always_comb begin
        rs1_v = rs1 == 5'd0 ? '0 : yazmac[rs1];
        rs2_v = rs2 == 5'd0 ? '0 : yazmac[rs2];
        imm = (opk == LUI || opk == AUIPC) ? {buyruk_r[31:12], 12'b0} :
              opk == JAL    ? {{12{buyruk_r[31]}}, buyruk_r[19:12], buyruk_r[20], buyruk_r[30:21], 1'b0} :
              opk == BRANCH ? {{20{buyruk_r[31]}}, buyruk_r[7], buyruk_r[30:25], buyruk_r[11:8], 1'b0} :
                              {{20{buyruk_r[31]}}, buyruk_r[31:20]};
        alu_op = ALU_ADD;
        if (opk == OP || opk == OP_IMM)
            case (f3)
                3'd0:    alu_op = (opk == OP && f7[5]) ? ALU_SUB : ALU_ADD;
                3'd1:    alu_op = ALU_SLL;
                3'd2:    alu_op = ALU_SLT;
                3'd3:    alu_op = ALU_SLTU;
                3'd4:    alu_op = ALU_XOR;
                3'd5:    alu_op = f7[5] ? ALU_SRA : ALU_SRL;
                3'd6:    alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        // Jumps reuse the adder for the link value ps + 4
        a = (opk == AUIPC || opk == JAL || opk == JALR) ? ps_r : opk == LUI ? '0 : rs1_v;
        b = (opk == OP || opk == BRANCH) ? rs2_v : (opk == JAL || opk == JALR) ? VERI_BIT'(4) : imm;
        case (opk)
            OP:              yasal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            OP_IMM:          yasal = f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            LUI, AUIPC, JAL: yasal = 1'b1;
            JALR:            yasal = f3 == 3'd0;
            BRANCH:          yasal = f3[2:1] != 2'b01;
            default:         yasal = 1'b0;
        endcase
    end
    aritmetik_mantik_birimi #(.VERI_BIT(VERI_BIT)) u_alu (
        .op(op_r), .a(a_r), .b(b_r), .sonuc(sonuc),
        .esit(esit), .kucuk(kucuk), .kucuk_isaretsiz(kucuk_i)
    );
    always_comb begin
        kosul = f3[2:1] == 2'b00 ? esit ^ f3[0] : f3[1] ? kucuk_i ^ f3[0] : kucuk ^ f3[0];
        hedef_ham = (opk == JALR ? rs1_r : ps_r) + imm_r;
        hedef = {hedef_ham[ADRES_BIT-1:1], hedef_ham[0] & (opk != JALR)};
        atla = opk == JAL || opk == JALR || (opk == BRANCH && kosul);
        gecersiz = !yasal || (atla && hedef[1:0] != 2'b00);
        sonraki = (atla && !gecersiz) ? hedef : ps_r + ADRES_BIT'(4);
        yaz = !gecersiz && rd != 5'd0 && opk != BRANCH;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) durum <= BOSTA;
        else durum <= sonraki_durum;
    always_comb begin
        sonraki_durum = durum;
        bus.buyruk_hazir = 1'b0;
        bus.sonraki_ps_gecerli = 1'b0;
        bus.gecersiz_buyruk = 1'b0;
        case (durum)
            BOSTA: begin
                bus.buyruk_hazir = 1'b1;
                sonraki_durum = bus.buyruk_gecerli ? COZ : BOSTA;
            end
            COZ:   sonraki_durum = YURUT;
            YURUT: sonraki_durum = GERIYAZ;
            default: begin
                bus.sonraki_ps_gecerli = 1'b1;
                bus.gecersiz_buyruk = gecersiz_r;
                sonraki_durum = BOSTA;
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            buyruk_r <= '0;
            ps_r <= '0;
            a_r <= '0;
            b_r <= '0;
            rs1_r <= '0;
            imm_r <= '0;
            op_r <= ALU_ADD;
            sonuc_r <= '0;
            yaz_r <= 1'b0;
            gecersiz_r <= 1'b0;
            bus.sonraki_ps <= '0;
            for (int i = 0; i < YAZMAC_SAYISI; i++) yazmac[i] <= '0;
        end else begin
            if (durum == BOSTA && bus.buyruk_gecerli) begin
                buyruk_r <= bus.buyruk;
                ps_r <= bus.buyruk_ps;
            end
            if (durum == COZ) begin
                a_r <= a;
                b_r <= b;
                rs1_r <= rs1_v;
                imm_r <= imm;
                op_r <= alu_op;
            end
            if (durum == YURUT) begin
                sonuc_r <= sonuc;
                yaz_r <= yaz;
                gecersiz_r <= gecersiz;
                bus.sonraki_ps <= sonraki;
            end
            if (durum == GERIYAZ && yaz_r) yazmac[rd] <= sonuc_r;
        end
endmodule
